ntt_coef_packer: RTL and testbench

Upstream feeder for the NTT/INTT operation core. It takes a job request (mode) and a stream of 256 12-bit polynomial coefficients. Each coefficient is reduced modulo q = 3329 and 11 coefficients are packed into the 132-bit `in` word of the core. The block issues the core's one-cycle `start`, holds `mode`, and pushes packed words with a one-cycle `validi` strobe, replacing the hand-driven stimulus used on the core today.

---
 rtl/ntt_pkg.sv | 36 +++
 rtl/mod_q_reduce.sv | 17 +
 rtl/ntt_coef_packer.sv | 163 ++++++++++++++++
 tb/tb_ntt_coef_packer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: constants shared by the NTT/INTT core, its coefficient packer and
// the benches.
//   Q          modulus (3329)
//   COEF_W     coefficient width in bits
//   LANES      coefficients packed into one core input word
//   N_COEF     coefficients per polynomial (one job)
//   DOUT_W     packed word width (LANES*COEF_W)
//   FORWARD_NTT_MODE / INVERSE_NTT_MODE  job mode codes
//   state_t    packer FSM state encoding
package ntt_pkg;

  localparam int Q          = 3329;
  localparam int COEF_W     = 12;
  localparam int LANES      = 11;
  localparam int N_COEF     = 256;
  localparam int DOUT_W     = LANES * COEF_W;
  localparam int LANE_CNT_W = 4;
  localparam int COEF_CNT_W = 9;

  localparam logic [2:0] FORWARD_NTT_MODE = 3'd0;
  localparam logic [2:0] INVERSE_NTT_MODE = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_LOAD  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Only the two transform directions are understood by the core.
  function automatic logic mode_supported(input logic [2:0] m);
    return (m == FORWARD_NTT_MODE) || (m == INVERSE_NTT_MODE);
  endfunction

endpackage

// File: rtl/mod_q_reduce.sv
// mod_q_reduce: combinational reduction of a 12-bit unsigned value mod Q.
//   c  input coefficient, 0..4095
//   r  c mod Q
// A single conditional subtract is exact because the largest input (4095)
// is below 2*Q.
module mod_q_reduce
  import ntt_pkg::*;
(
  input  logic [COEF_W-1:0] c,
  output logic [COEF_W-1:0] r
);

  localparam logic [COEF_W-1:0] Q_W = COEF_W'(Q);

  assign r = (c >= Q_W) ? (c - Q_W) : c;

endmodule

// File: rtl/ntt_coef_packer.sv
// ntt_coef_packer: feeds the NTT/INTT core. Accepts a job request, then 256
// coefficients, reduces each mod Q and packs 11 per 132-bit word.
//   clk, rst          clock, asynchronous active-high reset
//   cfg_valid/ready   job request handshake, cfg_mode = requested mode
//   coef_valid/ready  coefficient handshake, coef_data = raw coefficient
//   start             one-cycle job start to the core
//   mode              job mode held from start through done
//   validi/dout       one-cycle strobe with the packed word (lane k = [12k+11:12k])
//   done              one-cycle pulse after the final word
//   err               one-cycle pulse when a request carries an unknown mode
module ntt_coef_packer
  import ntt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [2:0]        cfg_mode,
  output logic              cfg_ready,
  input  logic              coef_valid,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_ready,
  output logic              start,
  output logic [2:0]        mode,
  output logic              validi,
  output logic [DOUT_W-1:0] dout,
  output logic              done,
  output logic              err
);

  state_t                  state_reg;
  state_t                  state_next;
  logic [2:0]              mode_reg;
  logic                    err_reg;
  logic                    validi_reg;
  logic [DOUT_W-1:0]       dout_reg;
  logic [DOUT_W-1:0]       pack_reg;
  logic [LANE_CNT_W-1:0]   lane_cnt_reg;
  logic [COEF_CNT_W-1:0]   coef_cnt_reg;

  logic                    cfg_fire;
  logic                    coef_fire;
  logic                    last_coef;
  logic                    word_full;
  logic [COEF_W-1:0]       coef_red;
  logic [DOUT_W-1:0]       word_next;

  mod_q_reduce u_reduce (
    .c (coef_data),
    .r (coef_red)
  );

  assign cfg_fire  = cfg_valid & cfg_ready;
  assign coef_fire = coef_valid & coef_ready;
  assign last_coef = (coef_cnt_reg == COEF_CNT_W'(N_COEF - 1));
  assign word_full = (lane_cnt_reg == LANE_CNT_W'(LANES - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cfg_ready  = 1'b0;
    coef_ready = 1'b0;
    start      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        // Unsupported modes are answered with err and leave us in IDLE.
        if (cfg_valid && mode_supported(cfg_mode)) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        start      = 1'b1;
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        coef_ready = 1'b1;
        if (coef_valid && last_coef) begin
          state_next = ST_FLUSH;
        end
      end
      // The final partial word is already on validi/dout during FLUSH.
      ST_FLUSH: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------- lane merge
  // word_next is the pack register with the current coefficient dropped
  // into lane lane_cnt; it is both the next pack value and the emitted word.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic lane_hit;
      assign lane_hit = coef_fire && (lane_cnt_reg == LANE_CNT_W'(gi));
      assign word_next[gi*COEF_W +: COEF_W] =
        lane_hit ? coef_red : pack_reg[gi*COEF_W +: COEF_W];
    end
  endgenerate

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg     <= FORWARD_NTT_MODE;
      err_reg      <= 1'b0;
      validi_reg   <= 1'b0;
      dout_reg     <= '0;
      pack_reg     <= '0;
      lane_cnt_reg <= '0;
      coef_cnt_reg <= '0;
    end else begin
      err_reg    <= cfg_fire && !mode_supported(cfg_mode);
      validi_reg <= 1'b0;

      if (cfg_fire && mode_supported(cfg_mode)) begin
        mode_reg <= cfg_mode;
      end else if (state_reg == ST_DONE) begin
        mode_reg <= FORWARD_NTT_MODE;
      end

      if (state_reg == ST_START) begin
        // Every job starts from an empty word regardless of history.
        pack_reg     <= '0;
        lane_cnt_reg <= '0;
        coef_cnt_reg <= '0;
      end else if (coef_fire) begin
        coef_cnt_reg <= coef_cnt_reg + COEF_CNT_W'(1);
        // Emit on a full word or on the last coefficient (partial word,
        // unused upper lanes already zero because the register was cleared).
        if (word_full || last_coef) begin
          validi_reg   <= 1'b1;
          dout_reg     <= word_next;
          pack_reg     <= '0;
          lane_cnt_reg <= '0;
        end else begin
          pack_reg     <= word_next;
          lane_cnt_reg <= lane_cnt_reg + LANE_CNT_W'(1);
        end
      end
    end
  end

  assign mode   = mode_reg;
  assign err    = err_reg;
  assign validi = validi_reg;
  assign dout   = dout_reg;

endmodule

// File: tb/tb_ntt_coef_packer.sv
// tb_ntt_coef_packer: directed self-checking bench for ntt_coef_packer.
module tb_ntt_coef_packer;
  import ntt_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic [2:0]        cfg_mode = 3'd0;
  logic              coef_valid = 1'b0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              cfg_ready;
  logic              coef_ready;
  logic              start;
  logic [2:0]        mode;
  logic              validi;
  logic [DOUT_W-1:0] dout;
  logic              done;
  logic              err;

  ntt_coef_packer dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_mode   (cfg_mode),
    .cfg_ready  (cfg_ready),
    .coef_valid (coef_valid),
    .coef_data  (coef_data),
    .coef_ready (coef_ready),
    .start      (start),
    .mode       (mode),
    .validi     (validi),
    .dout       (dout),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int asserts  = 0;
  int failures = 0;

  // stimulus source and hand-specified expected (reduced) values
  logic [COEF_W-1:0] src     [N_COEF];
  logic [COEF_W-1:0] exp_val [N_COEF];

  // monitor state
  logic [DOUT_W-1:0] words     [32];
  logic [2:0]        word_mode [32];
  int                word_cyc  [32];
  int word_cnt, start_cnt, err_cnt, done_cnt;
  int start_cyc, ready_cyc, done_cyc, back_cyc;
  logic [2:0] start_mode;

  always @(negedge clk) begin
    if (validi) begin
      if (word_cnt < 32) begin
        words[word_cnt]     = dout;
        word_mode[word_cnt] = mode;
        word_cyc[word_cnt]  = cyc;
      end
      word_cnt++;
    end
    if (start) begin
      start_cnt++;
      start_cyc  = cyc;
      start_mode = mode;
    end
    if (err) err_cnt++;
    if (coef_ready && ready_cyc < 0) ready_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cfg_ready && done_cyc >= 0 && back_cyc < 0) back_cyc = cyc;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    word_cnt = 0; start_cnt = 0; err_cnt = 0; done_cnt = 0;
    start_cyc = -1; ready_cyc = -1; done_cyc = -1; back_cyc = -1;
    start_mode = 3'd7;
    for (int i = 0; i < 32; i++) begin
      words[i] = '0; word_mode[i] = 3'd7; word_cyc[i] = -1;
    end
  endtask

  function automatic logic [DOUT_W-1:0] expected_word(input int w);
    logic [DOUT_W-1:0] x;
    x = '0;
    for (int k = 0; k < LANES; k++)
      if (w * LANES + k < N_COEF) x[k*COEF_W +: COEF_W] = exp_val[w*LANES + k];
    return x;
  endfunction

  // Issue a job request, then feed n_coef coefficients (one offer every
  // 'gap' cycles). With noise set, cfg_valid is held high during LOAD.
  task automatic run_job(input logic [2:0] m, input int gap, input bit noise,
                         input int n_coef, output int hs, output int last_acc);
    int idx;
    clear_mon();
    tick();
    cfg_valid = 1'b1;
    cfg_mode  = m;
    hs = cyc + 1;
    tick();
    cfg_valid = 1'b0;
    idx = 0;
    last_acc = -1;
    for (int n = 0; n < 2000 && idx < n_coef; n++) begin
      tick();
      if (noise) begin
        cfg_valid = (idx > 10 && idx < 200);
        cfg_mode  = 3'd1;
      end
      coef_valid = ((n % gap) == 0);
      coef_data  = src[idx];
      if (coef_valid && coef_ready) begin
        last_acc = cyc + 1;
        idx++;
      end
    end
    tick();
    coef_valid = 1'b0;
    cfg_valid  = 1'b0;
    if (idx < n_coef) begin
      asserts++; failures++;
      $display("FAIL feed_timeout: accepted %0d required %0d", idx, n_coef);
    end
    if (n_coef == N_COEF) repeat (5) tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      cfg_valid  = i[0];
      coef_valid = ~i[0];
      cfg_mode   = i[2:0];
      coef_data  = 12'(i * 777);
      asserts++;
      if (start !== 1'b0 || validi !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
          coef_ready !== 1'b0 || mode !== 3'd0 || dout !== '0 || cfg_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_outputs: start=%b validi=%b done=%b err=%b coef_ready=%b mode=%0d cfg_ready=%b required 0s and cfg_ready=1",
                 start, validi, done, err, coef_ready, mode, cfg_ready);
      end
    end
    tick();
    cfg_valid = 1'b0; coef_valid = 1'b0; cfg_mode = 3'd0;
    rst = 1'b0;
    clear_mon();
    repeat (5) tick();
    asserts++;
    if (start_cnt !== 0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle: start pulses %0d cfg_ready %b required 0 and 1", start_cnt, cfg_ready);
    end
  endtask

  task automatic test_forward();
    int hs, la;
    for (int i = 0; i < N_COEF; i++) begin src[i] = 12'(i); exp_val[i] = 12'(i); end
    run_job(FORWARD_NTT_MODE, 1, 1'b0, N_COEF, hs, la);
    asserts++;
    if (start_cnt !== 1 || start_cyc !== hs || start_mode !== 3'd0) begin
      failures++;
      $display("FAIL fwd_start: cnt %0d cyc %0d mode %0d required 1 %0d 0", start_cnt, start_cyc, start_mode, hs);
    end
    asserts++;
    if (ready_cyc !== hs + 1) begin
      failures++;
      $display("FAIL fwd_ready_first: got %0d required %0d", ready_cyc, hs + 1);
    end
    asserts++;
    if (word_cnt !== 24) begin
      failures++;
      $display("FAIL fwd_word_count: got %0d required 24", word_cnt);
    end
    for (int w = 0; w < 24; w++) begin
      asserts++;
      if (words[w] !== expected_word(w)) begin
        failures++;
        $display("FAIL fwd_word%0d: got %h required %h", w, words[w], expected_word(w));
      end
    end
    asserts++;
    if (word_cyc[1] - word_cyc[0] !== 11) begin
      failures++;
      $display("FAIL fwd_word_spacing: got %0d required 11", word_cyc[1] - word_cyc[0]);
    end
    asserts++;
    if (la !== hs + 257 || word_cyc[23] !== la) begin
      failures++;
      $display("FAIL fwd_flush_time: last accept %0d flush %0d required %0d %0d", la, word_cyc[23], hs + 257, hs + 257);
    end
    asserts++;
    if (done_cnt !== 1 || done_cyc !== la + 1 || back_cyc !== la + 2) begin
      failures++;
      $display("FAIL fwd_done_time: done %0d@%0d cfg_ready@%0d required 1@%0d %0d", done_cnt, done_cyc, back_cyc, la + 1, la + 2);
    end
  endtask

  task automatic test_reduction();
    int hs, la;
    for (int i = 0; i < N_COEF; i++) begin src[i] = 12'(i); exp_val[i] = 12'(i); end
    src[0] = 12'd3328; exp_val[0] = 12'd3328;
    src[1] = 12'd3329; exp_val[1] = 12'd0;
    src[2] = 12'd4095; exp_val[2] = 12'd766;
    src[3] = 12'd0;    exp_val[3] = 12'd0;
    run_job(INVERSE_NTT_MODE, 1, 1'b0, N_COEF, hs, la);
    asserts++;
    if (words[0][47:0] !== {12'd0, 12'd766, 12'd0, 12'd3328}) begin
      failures++;
      $display("FAIL red_lanes: got %h required %h", words[0][47:0], {12'd0, 12'd766, 12'd0, 12'd3328});
    end
    for (int w = 0; w < 24; w++) begin
      asserts++;
      if (words[w] !== expected_word(w) || word_mode[w] !== 3'd1) begin
        failures++;
        $display("FAIL red_word%0d: got %h mode %0d required %h mode 1", w, words[w], word_mode[w], expected_word(w));
      end
    end
    asserts++;
    if (start_mode !== 3'd1 || mode !== 3'd0) begin
      failures++;
      $display("FAIL red_mode: at start %0d after job %0d required 1 0", start_mode, mode);
    end
  endtask

  task automatic test_bad_mode();
    int hs, la;
    clear_mon();
    tick();
    cfg_valid = 1'b1;
    cfg_mode  = 3'd5;
    tick();
    cfg_valid = 1'b0;
    cfg_mode  = 3'd0;
    asserts++;
    if (err !== 1'b1 || start !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL bad_err: err %b start %b cfg_ready %b required 1 0 1", err, start, cfg_ready);
    end
    repeat (3) tick();
    asserts++;
    if (err_cnt !== 1 || start_cnt !== 0 || err !== 1'b0) begin
      failures++;
      $display("FAIL bad_pulse: err pulses %0d starts %0d required 1 0", err_cnt, start_cnt);
    end
    for (int i = 0; i < N_COEF; i++) begin src[i] = 12'(i); exp_val[i] = 12'(i); end
    run_job(FORWARD_NTT_MODE, 1, 1'b0, N_COEF, hs, la);
    asserts++;
    if (word_cnt !== 24 || words[0] !== expected_word(0) || words[23] !== expected_word(23)) begin
      failures++;
      $display("FAIL bad_followup: words %0d first %h required 24 %h", word_cnt, words[0], expected_word(0));
    end
  endtask

  task automatic test_gapped();
    int hs, la;
    for (int i = 0; i < N_COEF; i++) begin src[i] = 12'(i); exp_val[i] = 12'(i); end
    run_job(FORWARD_NTT_MODE, 3, 1'b1, N_COEF, hs, la);
    asserts++;
    if (word_cnt !== 24 || start_cnt !== 1 || err_cnt !== 0) begin
      failures++;
      $display("FAIL gap_counts: words %0d starts %0d errs %0d required 24 1 0", word_cnt, start_cnt, err_cnt);
    end
    for (int w = 0; w < 24; w++) begin
      asserts++;
      if (words[w] !== expected_word(w) || word_mode[w] !== 3'd0) begin
        failures++;
        $display("FAIL gap_word%0d: got %h mode %0d required %h mode 0", w, words[w], word_mode[w], expected_word(w));
      end
    end
  endtask

  task automatic test_reset_mid_job();
    int hs, la;
    for (int i = 0; i < N_COEF; i++) begin src[i] = 12'(i + 3000); exp_val[i] = 12'(i + 3000 >= Q ? i + 3000 - Q : i + 3000); end
    run_job(INVERSE_NTT_MODE, 1, 1'b0, 100, hs, la);
    asserts++;
    if (word_cnt !== 9 || dout !== expected_word(8) || mode !== 3'd1) begin
      failures++;
      $display("FAIL mid_before: words %0d dout %h mode %0d required 9 %h 1", word_cnt, dout, mode, expected_word(8));
    end
    rst = 1'b1;
    #1;
    asserts++;
    if (cfg_ready !== 1'b1 || coef_ready !== 1'b0 || dout !== '0 || mode !== 3'd0 ||
        validi !== 1'b0 || start !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL mid_async_clear: cfg_ready %b coef_ready %b dout %h mode %0d required 1 0 0 0",
               cfg_ready, coef_ready, dout, mode);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < N_COEF; i++) begin src[i] = 12'(i + 1000); exp_val[i] = 12'(i + 1000); end
    run_job(FORWARD_NTT_MODE, 1, 1'b0, N_COEF, hs, la);
    asserts++;
    if (word_cnt !== 24) begin
      failures++;
      $display("FAIL mid_next_count: got %0d required 24", word_cnt);
    end
    for (int w = 0; w < 24; w++) begin
      asserts++;
      if (words[w] !== expected_word(w)) begin
        failures++;
        $display("FAIL mid_next_word%0d: got %h required %h", w, words[w], expected_word(w));
      end
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_forward();
    test_reduction();
    test_bad_mode();
    test_gapped();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
